// File: rtl/slave_in_port.sv
// Serial slave input port: deserialises address, burst length and write data
// from the master's LSB-first serial lines into write strobes and read requests.
module slave_in_port #(
  parameter int SLAVE_ADDR_SIZE = 12,
  parameter int WORD_SIZE       = 8,
  parameter int BURST_SIZE      = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       slave_sel,
  input  logic                       addr_bus,
  input  logic                       w_data_bus,
  input  logic                       burst_size_bus,
  input  logic                       read_en,
  input  logic                       m_valid,
  input  logic                       m_b_tx_valid,
  input  logic                       tx_done,
  input  logic                       split_on,
  input  logic                       core_ready,
  output logic                       s_ready,
  output logic                       wr_en,
  output logic [SLAVE_ADDR_SIZE-1:0] wr_addr,
  output logic [WORD_SIZE-1:0]       wr_data,
  output logic                       rd_req,
  output logic [SLAVE_ADDR_SIZE-1:0] rd_addr,
  output logic [BURST_SIZE-1:0]      rd_len,
  output logic                       rx_err
);

  localparam int ACW = (SLAVE_ADDR_SIZE > 1) ? $clog2(SLAVE_ADDR_SIZE) : 1;
  localparam int WCW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int BCW = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;

  localparam logic [ACW-1:0] ADDR_LAST  = ACW'(SLAVE_ADDR_SIZE - 1);
  localparam logic [WCW-1:0] WORD_LAST  = WCW'(WORD_SIZE - 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_RX,
    DECODE,
    BURST_RX,
    DATA_RX,
    RD_REQ
  } state_t;

  state_t                     state, state_n;
  logic [ACW-1:0]             addr_cnt, addr_cnt_n;
  logic [BCW-1:0]             bcnt, bcnt_n;
  logic [WCW-1:0]             bit_cnt, bit_cnt_n;
  logic [SLAVE_ADDR_SIZE-1:0] word_idx, word_idx_n;
  logic [SLAVE_ADDR_SIZE-1:0] addr_sr, addr_sr_n;
  logic [BURST_SIZE-1:0]      len_sr, len_sr_n;
  logic [WORD_SIZE-1:0]       wsr, wsr_n;
  logic                       wr_en_n, rd_req_n, rx_err_n;
  logic [SLAVE_ADDR_SIZE-1:0] wr_addr_n, rd_addr_n;
  logic [WORD_SIZE-1:0]       wr_data_n;
  logic [BURST_SIZE-1:0]      rd_len_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_cnt <= '0;
      bcnt     <= '0;
      bit_cnt  <= '0;
      word_idx <= '0;
      addr_sr  <= '0;
      len_sr   <= '0;
      wsr      <= '0;
      s_ready  <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rx_err   <= 1'b0;
    end else begin
      state    <= state_n;
      addr_cnt <= addr_cnt_n;
      bcnt     <= bcnt_n;
      bit_cnt  <= bit_cnt_n;
      word_idx <= word_idx_n;
      addr_sr  <= addr_sr_n;
      len_sr   <= len_sr_n;
      wsr      <= wsr_n;
      s_ready  <= core_ready;
      wr_en    <= wr_en_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      rd_req   <= rd_req_n;
      rd_addr  <= rd_addr_n;
      rd_len   <= rd_len_n;
      rx_err   <= rx_err_n;
    end
  end

  // Strobes are registered on the edge that completes a field, so each
  // appears exactly one cycle after its last serial bit was sampled.
  always_comb begin
    state_n    = state;
    addr_cnt_n = addr_cnt;
    bcnt_n     = bcnt;
    bit_cnt_n  = bit_cnt;
    word_idx_n = word_idx;
    addr_sr_n  = addr_sr;
    len_sr_n   = len_sr;
    wsr_n      = wsr;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    rd_req_n   = 1'b0;
    rd_addr_n  = rd_addr;
    rd_len_n   = rd_len;
    rx_err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (slave_sel) begin
          state_n    = ADDR_RX;
          addr_cnt_n = '0;
        end
      end
      ADDR_RX: begin
        if (s_ready) begin
          addr_sr_n[addr_cnt] = addr_bus;
          if (addr_cnt == ADDR_LAST) state_n = DECODE;
          else                       addr_cnt_n = addr_cnt + ACW'(1);
        end
      end
      DECODE: begin
        if (m_b_tx_valid) begin
          state_n  = BURST_RX;
          bcnt_n   = '0;
          len_sr_n = '0;
        end else if (read_en) begin
          state_n   = RD_REQ;
          rd_req_n  = 1'b1;
          rd_addr_n = addr_sr;
          rd_len_n  = BURST_SIZE'(1);
        end else begin
          state_n    = DATA_RX;
          bit_cnt_n  = '0;
          word_idx_n = '0;
          wsr_n      = '0;
        end
      end
      BURST_RX: begin
        if (s_ready && m_b_tx_valid) begin
          len_sr_n[bcnt] = burst_size_bus;
          if (bcnt == BURST_LAST) begin
            state_n   = RD_REQ;
            rd_req_n  = 1'b1;
            rd_addr_n = addr_sr;
            rd_len_n  = (len_sr_n == '0) ? BURST_SIZE'(1) : len_sr_n;
          end else begin
            bcnt_n = bcnt + BCW'(1);
          end
        end
      end
      DATA_RX: begin
        if (tx_done) begin
          state_n   = IDLE;
          rx_err_n  = (bit_cnt != '0);
          bit_cnt_n = '0;
        end else if (s_ready && m_valid) begin
          wsr_n[bit_cnt] = w_data_bus;
          if (bit_cnt == WORD_LAST) begin
            wr_en_n    = 1'b1;
            wr_data_n  = wsr_n;
            wr_addr_n  = addr_sr + word_idx;
            word_idx_n = word_idx + SLAVE_ADDR_SIZE'(1);
            bit_cnt_n  = '0;
          end else begin
            bit_cnt_n = bit_cnt + WCW'(1);
          end
        end
      end
      RD_REQ: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Aborts override whatever the state logic decided, including completions.
    if (state != IDLE && (split_on || !slave_sel)) begin
      state_n    = IDLE;
      addr_cnt_n = '0;
      bcnt_n     = '0;
      bit_cnt_n  = '0;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      rd_req_n   = 1'b0;
      rd_addr_n  = rd_addr;
      rd_len_n   = rd_len;
      rx_err_n   = !split_on;
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// Directed bench for slave_in_port: drives the serial master protocol and
// compares collected strobes against hand-computed values.
module tb_slave_in_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_sel = 1'b0, addr_bus = 1'b0, w_data_bus = 1'b0, burst_size_bus = 1'b0;
  logic        read_en = 1'b0, m_valid = 1'b0, m_b_tx_valid = 1'b0, tx_done = 1'b0, split_on = 1'b0;
  logic        core_ready = 1'b0;
  logic        s_ready, wr_en, rd_req, rx_err;
  logic [11:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic [14:0] rd_len;

  int checks = 0;
  int errors = 0;
  int stall_low = 0;

  logic [11:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [11:0] ra_q[$];
  logic [14:0] rl_q[$];
  int          err_n = 0;
  int          overlap = 0;

  slave_in_port #(
    .SLAVE_ADDR_SIZE(12),
    .WORD_SIZE(8),
    .BURST_SIZE(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slave_sel(slave_sel),
    .addr_bus(addr_bus), .w_data_bus(w_data_bus), .burst_size_bus(burst_size_bus),
    .read_en(read_en), .m_valid(m_valid), .m_b_tx_valid(m_b_tx_valid),
    .tx_done(tx_done), .split_on(split_on), .core_ready(core_ready),
    .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (rd_req) begin
        ra_q.push_back(rd_addr);
        rl_q.push_back(rd_len);
      end
      if (rx_err) err_n++;
      if (wr_en && rd_req) overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // kind: 0 address, 1 burst length, 2 write data. A bit is only consumed in a
  // cycle where s_ready is high; otherwise the inverted bit is driven as garbage.
  task automatic send_bits(input logic [15:0] v, input int n, input int kind, input int stall_bit);
    int stall_left;
    int lowc;
    stall_left = 0;
    lowc = 0;
    for (int i = 0; i < n; i++) begin
      bit done;
      int guard;
      done = 1'b0;
      guard = 0;
      if (i == stall_bit) begin
        core_ready = 1'b0;
        stall_left = 3;
      end
      while (!done) begin
        logic b;
        logic consume;
        b = v[i];
        consume = s_ready;
        if (!consume) begin
          b = ~b;
          lowc++;
        end
        case (kind)
          0: addr_bus = b;
          1: begin burst_size_bus = b; m_b_tx_valid = 1'b1; end
          default: begin w_data_bus = b; m_valid = 1'b1; end
        endcase
        tick();
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) core_ready = 1'b1;
        end
        done = consume;
        guard++;
        if (guard > 20) begin
          check("bit_timeout", 32'(guard), 32'(0));
          done = 1'b1;
        end
      end
    end
    m_valid = 1'b0;
    m_b_tx_valid = 1'b0;
    stall_low = lowc;
  endtask

  // mode: 0 write, 1 single read, 2 burst read; returns with DECODE consumed.
  task automatic start_xfer(input logic [11:0] addr, input int mode);
    slave_sel = 1'b1;
    tick();
    send_bits({4'h0, addr}, 12, 0, -1);
    read_en = (mode == 1);
    m_b_tx_valid = (mode == 2);
    tick();
    read_en = 1'b0;
    m_b_tx_valid = 1'b0;
  endtask

  task automatic end_write();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    slave_sel = 1'b0;
    idle(3);
  endtask

  int wb, rb, eb;

  initial begin
    core_ready = 1'b1;
    idle(2);
    check("rst_s_ready", 32'(s_ready), 32'(0));
    check("rst_wr_en", 32'(wr_en), 32'(0));
    check("rst_rd_req", 32'(rd_req), 32'(0));
    check("rst_rx_err", 32'(rx_err), 32'(0));
    check("rst_wr_addr", 32'(wr_addr), 32'(0));
    check("rst_rd_len", 32'(rd_len), 32'(0));
    rst_n = 1'b1;
    tick();
    check("s_ready_after_rst", 32'(s_ready), 32'(1));
    idle(2);

    // single write
    wb = wa_q.size(); rb = ra_q.size(); eb = err_n;
    start_xfer(12'h0A5, 0);
    send_bits(16'h3C, 8, 2, -1);
    end_write();
    check("w1_count", 32'(wa_q.size() - wb), 32'(1));
    check("w1_addr", 32'(wa_q[wb]), 32'h0A5);
    check("w1_data", 32'(wd_q[wb]), 32'h3C);
    check("w1_no_rd", 32'(ra_q.size() - rb), 32'(0));
    check("w1_no_err", 32'(err_n - eb), 32'(0));

    // multi-word write with address wrap
    wb = wa_q.size(); eb = err_n;
    start_xfer(12'hFFF, 0);
    send_bits(16'h11, 8, 2, -1);
    send_bits(16'h22, 8, 2, -1);
    send_bits(16'h33, 8, 2, -1);
    end_write();
    check("w3_count", 32'(wa_q.size() - wb), 32'(3));
    check("w3_addr0", 32'(wa_q[wb]), 32'hFFF);
    check("w3_addr1", 32'(wa_q[wb+1]), 32'h000);
    check("w3_addr2", 32'(wa_q[wb+2]), 32'h001);
    check("w3_data0", 32'(wd_q[wb]), 32'h11);
    check("w3_data1", 32'(wd_q[wb+1]), 32'h22);
    check("w3_data2", 32'(wd_q[wb+2]), 32'h33);
    check("w3_no_err", 32'(err_n - eb), 32'(0));

    // single read
    wb = wa_q.size(); rb = ra_q.size(); eb = err_n;
    start_xfer(12'h123, 1);
    tick();
    slave_sel = 1'b0;
    idle(3);
    check("rd_count", 32'(ra_q.size() - rb), 32'(1));
    check("rd_addr", 32'(ra_q[rb]), 32'h123);
    check("rd_len", 32'(rl_q[rb]), 32'(1));
    check("rd_no_wr", 32'(wa_q.size() - wb), 32'(0));
    check("rd_no_err", 32'(err_n - eb), 32'(0));

    // burst read, length 5
    rb = ra_q.size();
    start_xfer(12'h010, 2);
    send_bits(16'd5, 15, 1, -1);
    tick();
    slave_sel = 1'b0;
    idle(3);
    check("b5_count", 32'(ra_q.size() - rb), 32'(1));
    check("b5_addr", 32'(ra_q[rb]), 32'h010);
    check("b5_len", 32'(rl_q[rb]), 32'(5));

    // burst read, length field 0
    rb = ra_q.size();
    start_xfer(12'h010, 2);
    send_bits(16'd0, 15, 1, -1);
    tick();
    slave_sel = 1'b0;
    idle(3);
    check("b0_count", 32'(ra_q.size() - rb), 32'(1));
    check("b0_len", 32'(rl_q[rb]), 32'(1));

    // slave_sel dropped after 4 data bits
    wb = wa_q.size(); eb = err_n;
    start_xfer(12'h055, 0);
    send_bits(16'hF, 4, 2, -1);
    slave_sel = 1'b0;
    idle(4);
    check("sel_drop_no_wr", 32'(wa_q.size() - wb), 32'(0));
    check("sel_drop_err", 32'(err_n - eb), 32'(1));

    // split during address phase
    wb = wa_q.size(); rb = ra_q.size(); eb = err_n;
    slave_sel = 1'b1;
    tick();
    send_bits(16'h01F, 5, 0, -1);
    split_on = 1'b1;
    tick();
    split_on = 1'b0;
    slave_sel = 1'b0;
    idle(4);
    check("split_no_wr", 32'(wa_q.size() - wb), 32'(0));
    check("split_no_rd", 32'(ra_q.size() - rb), 32'(0));
    check("split_no_err", 32'(err_n - eb), 32'(0));

    // full word then truncated word
    wb = wa_q.size(); eb = err_n;
    start_xfer(12'h200, 0);
    send_bits(16'h5A, 8, 2, -1);
    send_bits(16'h7, 3, 2, -1);
    end_write();
    check("trunc_wr_count", 32'(wa_q.size() - wb), 32'(1));
    check("trunc_addr", 32'(wa_q[wb]), 32'h200);
    check("trunc_data", 32'(wd_q[wb]), 32'h5A);
    check("trunc_err", 32'(err_n - eb), 32'(1));

    // core_ready stall of 3 cycles mid-word
    wb = wa_q.size(); eb = err_n;
    start_xfer(12'h0F0, 0);
    send_bits(16'hA7, 8, 2, 4);
    end_write();
    check("stall_low_cycles", 32'(stall_low), 32'(3));
    check("stall_wr_count", 32'(wa_q.size() - wb), 32'(1));
    check("stall_addr", 32'(wa_q[wb]), 32'h0F0);
    check("stall_data", 32'(wd_q[wb]), 32'hA7);
    check("stall_no_err", 32'(err_n - eb), 32'(0));

    // asynchronous reset mid-transfer
    start_xfer(12'h333, 0);
    send_bits(16'h3, 2, 2, -1);
    wb = wa_q.size(); rb = ra_q.size(); eb = err_n;
    #2;
    rst_n = 1'b0;
    slave_sel = 1'b0;
    #1;
    check("mid_rst_s_ready", 32'(s_ready), 32'(0));
    check("mid_rst_wr_addr", 32'(wr_addr), 32'(0));
    check("mid_rst_wr_data", 32'(wr_data), 32'(0));
    check("mid_rst_rd_addr", 32'(rd_addr), 32'(0));
    check("mid_rst_rd_len", 32'(rd_len), 32'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_s_ready_rel", 32'(s_ready), 32'(1));
    idle(4);
    check("mid_rst_no_wr", 32'(wa_q.size() - wb), 32'(0));
    check("mid_rst_no_rd", 32'(ra_q.size() - rb), 32'(0));
    check("mid_rst_no_err", 32'(err_n - eb), 32'(0));

    check("wr_rd_overlap", 32'(overlap), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slave_in_port.md
SLAVE_IN_PORT -- requirements
Module: slave_in_port

Interface
REQ-001: Parameter SLAVE_ADDR_SIZE, default 12, SHALL set the serial address bits per transfer and the width of the address outputs.
REQ-002: Parameter WORD_SIZE, default 8, SHALL set the serial data bits per word and the width of wr_data.
REQ-003: Parameter BURST_SIZE, default 15, SHALL set the serial burst-length bits and the width of rd_len.
REQ-004: clk  in  1  sole clock; all state changes SHALL occur on its rising edge.
REQ-005: rst_n  in  1  reset; it SHALL be asynchronous and active-low.
REQ-006: slave_sel  in  1  this slave's bit of the master slave_select vector.
REQ-007: addr_bus, w_data_bus, burst_size_bus  in  1 each  serial address, write data and burst length, all LSB first.
REQ-008: read_en, m_valid, m_b_tx_valid, tx_done, split_on  in  1 each  master qualifiers.
REQ-009: core_ready  in  1  slave core can accept a request.
REQ-010: s_ready  out  1  registered copy of core_ready; the master stalls while 0.
REQ-011: wr_en  out  1, wr_addr  out  SLAVE_ADDR_SIZE, wr_data  out  WORD_SIZE  one-cycle write strobe with address and data.
REQ-012: rd_req  out  1, rd_addr  out  SLAVE_ADDR_SIZE, rd_len  out  BURST_SIZE  one-cycle read request.
REQ-013: rx_err  out  1  one-cycle pulse on an aborted or truncated transfer.

Function
REQ-014: Each cycle, s_ready SHALL take the value of core_ready; a bus bit SHALL be sampled only in a cycle where s_ready=1.
REQ-015: The FSM SHALL have states IDLE, ADDR_RX, DECODE, BURST_RX, DATA_RX and RD_REQ.
REQ-016: IDLE SHALL move to ADDR_RX with addr_cnt=0 on the first cycle slave_sel=1.
REQ-017: ADDR_RX SHALL store addr_bus into addr_sr[addr_cnt] each sampling cycle and increment addr_cnt; after bit SLAVE_ADDR_SIZE-1 it SHALL go to DECODE.
REQ-018: DECODE SHALL last one cycle: m_b_tx_valid=1 goes to BURST_RX (bcnt=0); else read_en=1 goes to RD_REQ with len=1; else DATA_RX (bit_cnt=0, word_idx=0).
REQ-019: BURST_RX SHALL store burst_size_bus into len_sr[bcnt] on sampling cycles with m_b_tx_valid=1; after BURST_SIZE bits it SHALL go to RD_REQ.
REQ-020: A received burst length of 0 SHALL be issued as rd_len=1.
REQ-021: RD_REQ SHALL pulse rd_req for exactly one cycle with rd_addr=addr_sr and rd_len, then return to IDLE.
REQ-022: DATA_RX SHALL store w_data_bus into wsr[bit_cnt] on sampling cycles with m_valid=1.
REQ-023: After bit WORD_SIZE-1, the next cycle SHALL pulse wr_en with wr_data=wsr and wr_addr=(addr_sr+word_idx) mod 2^SLAVE_ADDR_SIZE, then word_idx++ and bit_cnt=0.
REQ-024: tx_done=1 in DATA_RX SHALL return to IDLE after any pending wr_en has issued.
REQ-025: If bit_cnt!=0 when tx_done=1, the partial word SHALL be discarded and rx_err SHALL pulse.
REQ-026: split_on=1 in any non-IDLE state SHALL force IDLE next cycle with no further wr_en or rd_req, and no rx_err.
REQ-027: slave_sel=0 in any non-IDLE state SHALL force IDLE, suppress outputs and pulse rx_err.
REQ-028: When an abort and a completion occur in the same cycle, the abort SHALL take priority.
REQ-029: wr_en and rd_req SHALL never be asserted in the same cycle.
REQ-030: Bit counters SHALL saturate and never index beyond their field widths.

Reset
REQ-031: While rst_n=0, the FSM SHALL be in IDLE, all counters and shift registers SHALL be 0, and s_ready, wr_en, rd_req and rx_err SHALL be 0.
REQ-032: While rst_n=0, wr_addr, wr_data, rd_addr and rd_len SHALL be 0.
REQ-033: Reset asserted mid-transfer SHALL discard the transfer with no strobe after release; the first cycle with core_ready=1 after release SHALL set s_ready=1.

Verification
REQ-034: Write of address 0x0A5, one word 0x3C, then tx_done -> one wr_en with wr_addr=0x0A5 and wr_data=0x3C, then IDLE.
REQ-035: Write of 3 words 0x11, 0x22, 0x33 to address 0xFFF -> wr_addr sequence 0xFFF, 0x000, 0x001 (wrap-around).
REQ-036: Single read of address 0x123 (read_en=1 in DECODE) -> one rd_req with rd_addr=0x123 and rd_len=1.
REQ-037: Burst read of address 0x010 with burst field 5 -> rd_req with rd_len=5; a burst field of 0 -> rd_len=1.
REQ-038: slave_sel dropped after 4 data bits -> IDLE, no wr_en, one rx_err; split_on in ADDR_RX -> IDLE, no rx_err.
REQ-039: core_ready=0 for 3 cycles mid-word -> s_ready=0 and no bits sampled during the stall; after resume, the word is received intact.
